// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two-requester round-robin front end sharing
// one registered 4-bit magnitude comparator.

module cmp4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       gt_o,
  output logic       eq_o,
  output logic       lt_o
);

  assign gt_o = a_i > b_i;
  assign eq_o = a_i == b_i;
  assign lt_o = a_i < b_i;

endmodule

module cmp_arbiter #(
  parameter int COUNT_W = 8
) (
  input  logic               cmp_arbiter_port_clk,
  input  logic               cmp_arbiter_port_rst_n,
  input  logic [1:0]         cmp_arbiter_port_req,
  input  logic [3:0]         cmp_arbiter_port_A0,
  input  logic [3:0]         cmp_arbiter_port_B0,
  input  logic [3:0]         cmp_arbiter_port_A1,
  input  logic [3:0]         cmp_arbiter_port_B1,
  output logic [1:0]         cmp_arbiter_oport_done,
  output logic [2:0]         cmp_arbiter_oport_P,
  output logic               cmp_arbiter_oport_gnt_id,
  output logic               cmp_arbiter_oport_busy,
  output logic [COUNT_W-1:0] cmp_arbiter_oport_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE =
    {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [3:0]         a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic [2:0]         p_q, p_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic win;
  logic gt, eq, lt;

  cmp4 u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .gt_o (gt),
    .eq_o (eq),
    .lt_o (lt)
  );

  // Lone requester wins; on contention the one not served last wins.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (cmp_arbiter_port_req == 2'b10): win = 1'b1;
      (cmp_arbiter_port_req == 2'b11): win = ~last_q;
      default:                         win = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmp_arbiter_port_req != 2'b00) begin
          a_d     = win ? cmp_arbiter_port_A1
                        : cmp_arbiter_port_A0;
          b_d     = win ? cmp_arbiter_port_B1
                        : cmp_arbiter_port_B0;
          gnt_d   = win;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        p_d     = {gt, eq, lt};
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = gnt_q;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cmp_arbiter_port_clk
              or negedge cmp_arbiter_port_rst_n) begin
    if (!cmp_arbiter_port_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmp_arbiter_oport_done =
    (state_q == S_DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign cmp_arbiter_oport_P      = p_q;
  assign cmp_arbiter_oport_gnt_id = gnt_q;
  assign cmp_arbiter_oport_busy   = state_q != S_IDLE;
  assign cmp_arbiter_oport_count  = cnt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed and random transactions against
// a transaction-level model of the arbiter.
module tb_cmp_arbiter;

  localparam int MAXC = 255;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] done;
  logic [2:0] p;
  logic       gnt;
  logic       busy;
  logic [7:0] cnt;

  int n_chk = 0;
  int n_err = 0;
  int m_cnt = 0;
  logic m_last = 1'b1;

  cmp_arbiter #(.COUNT_W(8)) dut (
    .cmp_arbiter_port_clk     (clk),
    .cmp_arbiter_port_rst_n   (rst_n),
    .cmp_arbiter_port_req     (req),
    .cmp_arbiter_port_A0      (a0),
    .cmp_arbiter_port_B0      (b0),
    .cmp_arbiter_port_A1      (a1),
    .cmp_arbiter_port_B1      (b1),
    .cmp_arbiter_oport_done   (done),
    .cmp_arbiter_oport_P      (p),
    .cmp_arbiter_oport_gnt_id (gnt),
    .cmp_arbiter_oport_busy   (busy),
    .cmp_arbiter_oport_count  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_p(input int a, input int b);
    return {a > b, a == b, a < b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_done", done, 0);
    chk("rst_p", p, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    m_cnt = 0;
    m_last = 1'b1;
  endtask

  task automatic idle(input int n);
    req = 0;
    repeat (n) begin
      tick();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic txn(input logic [1:0] r,
                     input logic [3:0] xa0, input logic [3:0] xb0,
                     input logic [3:0] xa1, input logic [3:0] xb1,
                     input bit chg, input logic [3:0] chg_a1,
                     input bit drop);
    logic w;
    logic [2:0] ep;
    chk("start_busy", busy, 0);
    w = (r == 2'b11) ? ~m_last : r[1];
    ep = w ? exp_p(int'(xa1), int'(xb1))
           : exp_p(int'(xa0), int'(xb0));
    req = r; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    tick();
    chk("cmp_busy", busy, 1);
    chk("cmp_done", done, 0);
    chk("cmp_gnt", gnt, w);
    if (chg) begin
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = chg_a1;       b1 = 4'($urandom);
    end
    if (drop) req = 0;
    tick();
    chk("done", done, w ? 2'b10 : 2'b01);
    chk("done_p", p, ep);
    chk("done_busy", busy, 1);
    m_last = w;
    m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("count", cnt, m_cnt);
    chk("p_hold", p, ep);
    chk("gnt_hold", gnt, w);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    do_reset();

    // single request
    txn(2'b01, 4'd5, 4'd3, 4'd0, 4'd0, 0, 4'd0, 0);
    chk("single_p", p, 3'b100);
    chk("single_cnt", cnt, 1);
    idle(2);

    // contention with req held high
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, 4'd2, 4'd2, 4'd1, 4'd9, 0, 4'd0, 0);
      chk("cont_gnt", gnt, i % 2);
      chk("cont_p", p, (i % 2) ? 3'b001 : 3'b010);
    end
    idle(2);

    // operands latched at grant
    txn(2'b10, 4'd0, 4'd0, 4'd7, 4'd4, 1, 4'd0, 0);
    chk("latch_p", p, 3'b100);
    idle(1);

    // reset in the CMP cycle
    req = 2'b01; a0 = 4'd5; b0 = 4'd3;
    tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_p", p, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", cnt, 0);
    tick();
    rst_n = 1'b1;
    m_cnt = 0;
    m_last = 1'b1;
    idle(4);
    chk("rst_cnt_after", cnt, 0);
    txn(2'b11, 4'd8, 4'd1, 4'd1, 4'd8, 0, 4'd0, 0);
    idle(1);

    // exhaustive sweep through requester 1
    do_reset();
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        txn(2'b10, 4'($urandom), 4'($urandom), 4'(a), 4'(b),
            1'($urandom), 4'($urandom), 1'($urandom));
    chk("sweep_cnt", cnt, 100);
    idle(1);

    // random mix
    for (int i = 0; i < 200; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      if (r == 0) idle($urandom_range(1, 3));
      else txn(r, 4'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom),
               1'($urandom), 4'($urandom), 1'($urandom));
    end
    idle(1);

    // counter saturation
    do_reset();
    for (int i = 0; i < 260; i++)
      txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom),
          4'($urandom), 4'($urandom), 0, 4'd0, 0);
    chk("sat_cnt", cnt, 255);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The block SHALL have one parameter: COUNT_W, default 8, width of the completed-transaction counter.
REQ-002 The block SHALL have port cmp_arbiter_port_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port cmp_arbiter_port_rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port cmp_arbiter_port_req  input  2  level request; bit k belongs to requester k.
REQ-005 The block SHALL have ports cmp_arbiter_port_A0 and cmp_arbiter_port_B0  input  4 each  requester 0 operands.
REQ-006 The block SHALL have ports cmp_arbiter_port_A1 and cmp_arbiter_port_B1  input  4 each  requester 1 operands.
REQ-007 The block SHALL have port cmp_arbiter_oport_done  output  2  one-hot, one-cycle completion pulse to the granted requester.
REQ-008 The block SHALL have port cmp_arbiter_oport_P  output  3  registered compare result, {A>B, A==B, A<B}.
REQ-009 The block SHALL have port cmp_arbiter_oport_gnt_id  output  1  index of the requester currently or last granted.
REQ-010 The block SHALL have port cmp_arbiter_oport_busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL have port cmp_arbiter_oport_count  output  COUNT_W  number of completed transactions, saturating.

Function
REQ-012 The block SHALL contain one instance of the existing 4-bit comparator.
- That instance is shared by both requesters.
- It is fed only from internal latched operand registers.
REQ-013 The FSM SHALL have exactly three states: IDLE, CMP and DONE; encodings other than these three SHALL return to IDLE.
REQ-014 In IDLE, with req != 0 at a rising edge, the block SHALL perform these actions on that edge:
- select a winner;
- latch the winner's A/B into the operand registers;
- set gnt_id to the winner;
- enter CMP.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE and hold P, gnt_id and count.
REQ-016 Arbitration SHALL follow these rules:
- single requester: that requester is granted;
- both requesting: the requester not granted last time is granted (round-robin);
- the last-granted pointer resets to 1, so requester 0 wins the first contended arbitration.
REQ-017 In CMP, the block SHALL register the comparator output into P and enter DONE on the next edge.
REQ-018 In DONE, the block SHALL perform these actions:
- drive done[gnt_id]=1 for exactly one cycle, with P valid;
- update the last-granted pointer to gnt_id;
- increment count unless it equals 2^COUNT_W-1, where it holds;
- return to IDLE on the next edge.
REQ-019 Latency SHALL be fixed: done is high in the second cycle after the IDLE cycle in which req was sampled.
- Maximum throughput is one transaction per 3 cycles.
REQ-020 Operand inputs SHALL be ignored outside the IDLE sampling edge.
- Changes during CMP or DONE do not affect P.
REQ-021 Deasserting the granted req during CMP or DONE SHALL NOT abort the transaction; done still pulses.
REQ-022 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-023 P and gnt_id SHALL hold their values after DONE until the next CMP or DONE update.
REQ-024 At most one done bit SHALL ever be high, and only in DONE; busy SHALL be 0 only in IDLE.

Reset
REQ-025 While rst_n=0, asynchronously and regardless of clock, the block SHALL be in the following condition:
- state=IDLE;
- done=00, P=000, gnt_id=0, busy=0, count=0;
- last-granted pointer=1;
- operand registers=0.
REQ-026 Reset during CMP or DONE SHALL discard the in-flight transaction: no done pulse, count unchanged from 0.
REQ-027 After rst_n rises, the first rising edge SHALL be able to sample req in IDLE.

Verification
REQ-028 The bench SHALL cover a single request: req=01, A0=5, B0=3, held one cycle.
- Required response: busy for 2 cycles, then done=01 in cycle 3, P=100, gnt_id=0, count=1.
REQ-029 The bench SHALL cover contention: req=11 held, A0=B0=2, A1=1, B1=9.
- Required response: grants alternate 0,1,0,1.
- P alternates 010 and 001.
- done alternates 01 and 10 every 3 cycles.
- count increments by 1 per done.
REQ-030 The bench SHALL cover latched operands: req=10, A1=7, B1=4; change A1 to 0 in the CMP cycle.
- Required response: P=100, done=10.
REQ-031 The bench SHALL cover reset mid-operation: drop rst_n in the CMP cycle.
- Required response: all outputs 0 immediately; no done after release; count=0.
REQ-032 The bench SHALL cover an exhaustive sweep via requester 1: A1 in 0..9 x B1 in 0..9, 100 transactions.
- Required response: each P matches the ordering of A1 and B1; count=100.
REQ-033 The bench SHALL cover saturation: run 260 transactions with COUNT_W=8.
- Required response: count reaches 255 and holds; done pulses continue.
